// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, deserialises 11-bit frames
// and folds the E0/F0/E1 prefixes into single key make/break events.
module ps2_kbd_rx #(
   parameter int unsigned FILTER  = 8,
   parameter int unsigned TIMEOUT = 4000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       raw_strobe,
   output logic [7:0] raw_byte,
   output logic       key_strobe,
   output logic [7:0] key_code,
   output logic       key_extended,
   output logic       key_pressed,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned       TO_W     = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
   localparam logic [7:0]        FLT_LAST = 8'(FILTER - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // input conditioning
   logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic            data_s1_q, data_s1_d, data_s2_q, data_s2_d;
   logic            clk_f_q, clk_f_d, clk_f_dly_q, clk_f_dly_d;
   logic [7:0]      flt_cnt_q, flt_cnt_d;
   logic            fall_edge;

   // frame FSM
   state_t          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            parity_q, parity_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            timeout;
   logic            raw_strobe_q, raw_strobe_d;
   logic [7:0]      raw_byte_q, raw_byte_d;
   logic            frame_err_q, frame_err_d;
   logic            bad_frame_q, bad_frame_d;

   // prefix decoder
   logic            ext_q, ext_d, rel_q, rel_d;
   logic [2:0]      skip_q, skip_d;
   logic            key_strobe_q, key_strobe_d;
   logic [7:0]      key_code_q, key_code_d;
   logic            key_extended_q, key_extended_d;
   logic            key_pressed_q, key_pressed_d;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      clk_s1_d    = ps2_clk;
      clk_s2_d    = clk_s1_q;
      data_s1_d   = ps2_data;
      data_s2_d   = data_s1_q;
      clk_f_dly_d = clk_f_q;
      clk_f_d     = clk_f_q;
      flt_cnt_d   = flt_cnt_q;
      // clk_f only follows the line once it has disagreed for FILTER samples in a row
      if (clk_s2_q == clk_f_q) begin
         flt_cnt_d = 8'd0;
      end else if (flt_cnt_q >= FLT_LAST) begin
         clk_f_d   = clk_s2_q;
         flt_cnt_d = 8'd0;
      end else begin
         flt_cnt_d = flt_cnt_q + 8'd1;
      end
   end

   assign fall_edge = clk_f_dly_q & ~clk_f_q;
   assign timeout   = (state_q != S_IDLE) && !fall_edge && (to_cnt_q == TO_MAX);

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      raw_byte_d   = raw_byte_q;
      raw_strobe_d = 1'b0;
      frame_err_d  = 1'b0;
      bad_frame_d  = 1'b0;

      if (state_q == S_IDLE || fall_edge) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TO_MAX) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end else begin
         to_cnt_d = to_cnt_q;
      end

      if (fall_edge) begin
         unique case (state_q)
            S_IDLE: begin
               if (!data_s2_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            S_DATA: begin
               shift_d   = {data_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               parity_d = data_s2_q;
               state_d  = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               if ((^{shift_q, parity_q}) && data_s2_q) begin
                  raw_strobe_d = 1'b1;
                  raw_byte_d   = shift_q;
               end else begin
                  frame_err_d = 1'b1;
                  bad_frame_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if (timeout) begin
         // partial byte is dropped, prefix flags deliberately left alone
         state_d     = S_IDLE;
         frame_err_d = 1'b1;
      end
   end

   always_comb begin
      ext_d          = ext_q;
      rel_d          = rel_q;
      skip_d         = skip_q;
      key_strobe_d   = 1'b0;
      key_code_d     = key_code_q;
      key_extended_d = key_extended_q;
      key_pressed_d  = key_pressed_q;

      if (bad_frame_q) begin
         ext_d  = 1'b0;
         rel_d  = 1'b0;
         skip_d = 3'd0;
      end else if (raw_strobe_q) begin
         if (skip_q != 3'd0) begin
            // Pause: E1 plus seven trailing bytes collapse into one event on the last byte
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
               key_strobe_d   = 1'b1;
               key_code_d     = 8'hE1;
               key_extended_d = 1'b0;
               key_pressed_d  = 1'b1;
               ext_d          = 1'b0;
               rel_d          = 1'b0;
            end
         end else begin
            unique case (raw_byte_q)
               8'hE1: skip_d = 3'd7;
               8'hE0: ext_d  = 1'b1;
               8'hF0: rel_d  = 1'b1;
               8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                  ext_d = 1'b0;
                  rel_d = 1'b0;
               end
               default: begin
                  key_strobe_d   = 1'b1;
                  key_code_d     = raw_byte_q;
                  key_extended_d = ext_q;
                  key_pressed_d  = ~rel_q;
                  ext_d          = 1'b0;
                  rel_d          = 1'b0;
               end
            endcase
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_s1_q       <= 1'b1;
         clk_s2_q       <= 1'b1;
         data_s1_q      <= 1'b1;
         data_s2_q      <= 1'b1;
         clk_f_q        <= 1'b1;
         clk_f_dly_q    <= 1'b1;
         flt_cnt_q      <= 8'd0;
         state_q        <= S_IDLE;
         bit_cnt_q      <= 3'd0;
         shift_q        <= 8'd0;
         parity_q       <= 1'b0;
         to_cnt_q       <= '0;
         raw_strobe_q   <= 1'b0;
         raw_byte_q     <= 8'd0;
         frame_err_q    <= 1'b0;
         bad_frame_q    <= 1'b0;
         ext_q          <= 1'b0;
         rel_q          <= 1'b0;
         skip_q         <= 3'd0;
         key_strobe_q   <= 1'b0;
         key_code_q     <= 8'd0;
         key_extended_q <= 1'b0;
         key_pressed_q  <= 1'b0;
      end else begin
         clk_s1_q       <= clk_s1_d;
         clk_s2_q       <= clk_s2_d;
         data_s1_q      <= data_s1_d;
         data_s2_q      <= data_s2_d;
         clk_f_q        <= clk_f_d;
         clk_f_dly_q    <= clk_f_dly_d;
         flt_cnt_q      <= flt_cnt_d;
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         parity_q       <= parity_d;
         to_cnt_q       <= to_cnt_d;
         raw_strobe_q   <= raw_strobe_d;
         raw_byte_q     <= raw_byte_d;
         frame_err_q    <= frame_err_d;
         bad_frame_q    <= bad_frame_d;
         ext_q          <= ext_d;
         rel_q          <= rel_d;
         skip_q         <= skip_d;
         key_strobe_q   <= key_strobe_d;
         key_code_q     <= key_code_d;
         key_extended_q <= key_extended_d;
         key_pressed_q  <= key_pressed_d;
      end
   end

   assign raw_strobe   = raw_strobe_q;
   assign raw_byte     = raw_byte_q;
   assign key_strobe   = key_strobe_q;
   assign key_code     = key_code_q;
   assign key_extended = key_extended_q;
   assign key_pressed  = key_pressed_q;
   assign frame_err    = frame_err_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames bit by bit and checks raw bytes,
// decoded key events, frame errors, timeout, glitch rejection and mid-frame reset.
module tb_ps2_kbd_rx;

   localparam int FILTER  = 8;
   localparam int TIMEOUT = 4000;
   localparam int HALF    = 20;

   logic       clk_sys  = 1'b0;
   logic       reset    = 1'b1;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic       raw_strobe, key_strobe, key_extended, key_pressed, frame_err, busy;
   logic [7:0] raw_byte, key_code;

   int total = 0;
   int bad   = 0;

   // event monitor, sampled away from the active edge
   int cyc = 0, n_raw = 0, n_key = 0, n_err = 0;
   int raw_cyc = 0, key_cyc = 0, err_cyc = 0;

   ps2_kbd_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .raw_strobe   (raw_strobe),
      .raw_byte     (raw_byte),
      .key_strobe   (key_strobe),
      .key_code     (key_code),
      .key_extended (key_extended),
      .key_pressed  (key_pressed),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      cyc <= cyc + 1;
      if (raw_strobe) begin
         n_raw   <= n_raw + 1;
         raw_cyc <= cyc;
      end
      if (key_strobe) begin
         n_key   <= n_key + 1;
         key_cyc <= cyc;
      end
      if (frame_err) begin
         n_err   <= n_err + 1;
         err_cyc <= cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
   endtask

   // nbits < 11 truncates the frame after that many bits
   task automatic send_frame(input logic [7:0] b, input logic flip_parity, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ flip_parity, b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(f[i]);
      tick(HALF);
   endtask

   task automatic test_reset;
      tick(2);
      total++;
      if ({raw_strobe, raw_byte, key_strobe, key_code, key_extended, key_pressed, frame_err, busy} !== 22'd0)
         begin bad++; $display("FAIL reset_held outputs=%h want 0", {raw_strobe, raw_byte, key_strobe, key_code, key_extended, key_pressed, frame_err, busy}); end
      reset = 1'b0;
      tick(5);
      total++;
      if ({raw_strobe, raw_byte, key_strobe, key_code, key_extended, key_pressed, frame_err, busy} !== 22'd0)
         begin bad++; $display("FAIL reset_release outputs=%h want 0", {raw_strobe, raw_byte, key_strobe, key_code, key_extended, key_pressed, frame_err, busy}); end
   endtask

   task automatic test_make;
      int r0, k0, e0;
      r0 = n_raw; k0 = n_key; e0 = n_err;
      send_frame(8'h1C, 1'b0, 11);
      total++; if (n_raw - r0 !== 1) begin bad++; $display("FAIL make_raw_cnt got=%0d want=1", n_raw - r0); end
      total++; if (raw_byte !== 8'h1C) begin bad++; $display("FAIL make_raw_byte got=%h want=1c", raw_byte); end
      total++; if (n_key - k0 !== 1) begin bad++; $display("FAIL make_key_cnt got=%0d want=1", n_key - k0); end
      total++; if (key_cyc !== raw_cyc + 1) begin bad++; $display("FAIL make_key_latency got=%0d want=%0d", key_cyc, raw_cyc + 1); end
      total++; if ({key_code, key_extended, key_pressed} !== {8'h1C, 1'b0, 1'b1})
         begin bad++; $display("FAIL make_key code=%h ext=%b prs=%b want 1c/0/1", key_code, key_extended, key_pressed); end
      total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL make_no_err got=%0d want=0", n_err - e0); end
   endtask

   task automatic test_ext_break;
      int r0, k0;
      r0 = n_raw; k0 = n_key;
      send_frame(8'hE0, 1'b0, 11);
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h75, 1'b0, 11);
      total++; if (n_raw - r0 !== 3) begin bad++; $display("FAIL extbrk_raw_cnt got=%0d want=3", n_raw - r0); end
      total++; if (n_key - k0 !== 1) begin bad++; $display("FAIL extbrk_key_cnt got=%0d want=1", n_key - k0); end
      total++; if ({key_code, key_extended, key_pressed} !== {8'h75, 1'b1, 1'b0})
         begin bad++; $display("FAIL extbrk_key code=%h ext=%b prs=%b want 75/1/0", key_code, key_extended, key_pressed); end
   endtask

   task automatic test_parity_err;
      int r0, k0, e0;
      r0 = n_raw; k0 = n_key; e0 = n_err;
      send_frame(8'h29, 1'b1, 11);
      total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL parity_err_cnt got=%0d want=1", n_err - e0); end
      total++; if (n_raw - r0 !== 0) begin bad++; $display("FAIL parity_no_raw got=%0d want=0", n_raw - r0); end
      send_frame(8'h29, 1'b0, 11);
      total++; if (n_key - k0 !== 1) begin bad++; $display("FAIL parity_next_cnt got=%0d want=1", n_key - k0); end
      total++; if ({key_code, key_extended, key_pressed} !== {8'h29, 1'b0, 1'b1})
         begin bad++; $display("FAIL parity_next_key code=%h ext=%b prs=%b want 29/0/1", key_code, key_extended, key_pressed); end
   endtask

   task automatic test_err_clears_flags;
      int k0;
      k0 = n_key;
      send_frame(8'hE0, 1'b0, 11);
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h11, 1'b1, 11);
      send_frame(8'h1C, 1'b0, 11);
      total++; if (n_key - k0 !== 1) begin bad++; $display("FAIL errclr_key_cnt got=%0d want=1", n_key - k0); end
      total++; if ({key_code, key_extended, key_pressed} !== {8'h1C, 1'b0, 1'b1})
         begin bad++; $display("FAIL errclr_key code=%h ext=%b prs=%b want 1c/0/1", key_code, key_extended, key_pressed); end
   endtask

   task automatic test_timeout;
      int r0, k0, e0, t0;
      r0 = n_raw; k0 = n_key; e0 = n_err;
      send_frame(8'h5A, 1'b0, 5);
      t0 = cyc - 2 * HALF;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_busy_mid got=%b want=1", busy); end
      for (int i = 0; i < TIMEOUT + 100 && n_err == e0; i++) tick(1);
      total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL timeout_err_cnt got=%0d want=1", n_err - e0); end
      total++; if (err_cyc - t0 < TIMEOUT || err_cyc - t0 > TIMEOUT + 20)
         begin bad++; $display("FAIL timeout_latency got=%0d want %0d..%0d", err_cyc - t0, TIMEOUT, TIMEOUT + 20); end
      tick(2);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy_after got=%b want=0", busy); end
      total++; if (n_raw - r0 !== 0) begin bad++; $display("FAIL timeout_no_raw got=%0d want=0", n_raw - r0); end
      send_frame(8'h5A, 1'b0, 11);
      total++; if (n_key - k0 !== 1) begin bad++; $display("FAIL timeout_next_cnt got=%0d want=1", n_key - k0); end
      total++; if ({key_code, key_extended, key_pressed} !== {8'h5A, 1'b0, 1'b1})
         begin bad++; $display("FAIL timeout_next_key code=%h ext=%b prs=%b want 5a/0/1", key_code, key_extended, key_pressed); end
   endtask

   task automatic test_pause;
      int r0, k0;
      logic [7:0] seq [8];
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      r0 = n_raw; k0 = n_key;
      for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b0, 11);
      total++; if (n_raw - r0 !== 8) begin bad++; $display("FAIL pause_raw_cnt got=%0d want=8", n_raw - r0); end
      total++; if (n_key - k0 !== 1) begin bad++; $display("FAIL pause_key_cnt got=%0d want=1", n_key - k0); end
      total++; if ({key_code, key_extended, key_pressed} !== {8'hE1, 1'b0, 1'b1})
         begin bad++; $display("FAIL pause_key code=%h ext=%b prs=%b want e1/0/1", key_code, key_extended, key_pressed); end
   endtask

   task automatic test_ignore;
      int r0, k0;
      r0 = n_raw; k0 = n_key;
      send_frame(8'hAA, 1'b0, 11);
      total++; if (n_raw - r0 !== 1) begin bad++; $display("FAIL ignore_raw_cnt got=%0d want=1", n_raw - r0); end
      total++; if (n_key - k0 !== 0) begin bad++; $display("FAIL ignore_key_cnt got=%0d want=0", n_key - k0); end
   endtask

   task automatic test_glitch;
      int r0, k0, e0;
      r0 = n_raw; k0 = n_key; e0 = n_err;
      ps2_data = 1'b0;
      tick(HALF);
      for (int i = 0; i < 3; i++) begin
         ps2_clk = 1'b0;
         tick(FILTER - 3);
         ps2_clk = 1'b1;
         tick(10);
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy[%0d] got=%b want=0", i, busy); end
      end
      ps2_data = 1'b1;
      tick(HALF);
      total++; if (n_raw - r0 !== 0 || n_err - e0 !== 0)
         begin bad++; $display("FAIL glitch_no_event raw=%0d err=%0d want 0/0", n_raw - r0, n_err - e0); end
      send_frame(8'h24, 1'b0, 11);
      total++; if (n_key - k0 !== 1 || key_code !== 8'h24)
         begin bad++; $display("FAIL glitch_next_key cnt=%0d code=%h want 1/24", n_key - k0, key_code); end
   endtask

   task automatic test_back_to_back;
      int k0;
      k0 = n_key;
      send_frame(8'h1C, 1'b0, 11);
      send_frame(8'h32, 1'b0, 11);
      total++; if (n_key - k0 !== 2 || key_code !== 8'h32)
         begin bad++; $display("FAIL b2b_keys cnt=%0d code=%h want 2/32", n_key - k0, key_code); end
   endtask

   task automatic test_reset_mid;
      int k0;
      send_frame(8'h16, 1'b0, 6);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b want=1", busy); end
      reset = 1'b1;
      tick(3);
      total++;
      if ({raw_strobe, raw_byte, key_strobe, key_code, key_extended, key_pressed, frame_err, busy} !== 22'd0)
         begin bad++; $display("FAIL rstmid_outputs=%h want 0", {raw_strobe, raw_byte, key_strobe, key_code, key_extended, key_pressed, frame_err, busy}); end
      reset = 1'b0;
      tick(5);
      k0 = n_key;
      send_frame(8'h16, 1'b0, 11);
      total++; if (n_key - k0 !== 1 || {key_code, key_extended, key_pressed} !== {8'h16, 1'b0, 1'b1})
         begin bad++; $display("FAIL rstmid_next_key cnt=%0d code=%h ext=%b prs=%b want 1/16/0/1", n_key - k0, key_code, key_extended, key_pressed); end
   endtask

   initial begin
      reset = 1'b1;
      tick(3);
      test_reset;
      test_make;
      test_ext_break;
      test_parity_err;
      test_err_clears_flags;
      test_timeout;
      test_pause;
      test_ignore;
      test_glitch;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
